// File: rtl/pspin_ingress_writer.sv
// Writes matched frames into fixed-size L2 slots and emits one (addr,len) descriptor per frame; 1-cycle s_axis->m_wr latency.
// Backpressure: tready drops while the write register is stalled, all slots are in use, or a descriptor is pending.
module pspin_ingress_writer #(
   parameter int                    AXIS_IF_DATA_WIDTH = 512,
   parameter int                    AXIS_IF_KEEP_WIDTH = AXIS_IF_DATA_WIDTH / 8,
   parameter int                    ADDR_WIDTH         = 32,
   parameter logic [ADDR_WIDTH-1:0] BUF_BASE           = '0,
   parameter int                    SLOT_SIZE          = 2048,
   parameter int                    SLOT_COUNT         = 8,
   parameter int                    LEN_WIDTH          = 16
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [AXIS_IF_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [AXIS_IF_KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   input  logic                          s_axis_tlast,
   output logic [ADDR_WIDTH-1:0]         m_wr_addr,
   output logic [AXIS_IF_DATA_WIDTH-1:0] m_wr_data,
   output logic [AXIS_IF_KEEP_WIDTH-1:0] m_wr_strb,
   output logic                          m_wr_valid,
   input  logic                          m_wr_ready,
   output logic [ADDR_WIDTH-1:0]         m_desc_addr,
   output logic [LEN_WIDTH-1:0]          m_desc_len,
   output logic                          m_desc_valid,
   input  logic                          m_desc_ready,
   input  logic                          s_free_valid,
   output logic [$clog2(SLOT_COUNT):0]   slots_used,
   output logic [31:0]                   drop_count
);

   localparam int SLOT_W = $clog2(SLOT_COUNT);
   localparam int SU_W   = SLOT_W + 1;
   localparam int BEATS  = SLOT_SIZE / AXIS_IF_KEEP_WIDTH;
   localparam int BIDX_W = $clog2(BEATS + 1);

   typedef enum logic [2:0] {IDLE, WRITE, WAIT_WR, DESC, DROP} state_t;

   state_t                          state_q, state_d;
   logic                            run_q, run_d;
   logic [SLOT_W-1:0]               wr_slot_q, wr_slot_d;
   logic [BIDX_W-1:0]               beat_idx_q, beat_idx_d;
   logic [LEN_WIDTH-1:0]            len_q, len_d;
   logic [SU_W-1:0]                 slots_used_q, slots_used_d;
   logic [31:0]                     drop_count_q, drop_count_d;
   logic                            wr_vld_q, wr_vld_d;
   logic [ADDR_WIDTH-1:0]           wr_addr_q, wr_addr_d;
   logic [AXIS_IF_DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic [AXIS_IF_KEEP_WIDTH-1:0]   wr_strb_q, wr_strb_d;

   logic                            wr_free;
   logic                            in_hs;
   logic                            overflow;
   logic                            load;
   logic                            desc_hs;
   logic                            free_ok;
   logic                            drop_done;
   logic [ADDR_WIDTH-1:0]           slot_base;
   logic [ADDR_WIDTH-1:0]           beat_addr;
   logic [LEN_WIDTH-1:0]            beat_bytes;

   function automatic logic [LEN_WIDTH-1:0] popcnt(input logic [AXIS_IF_KEEP_WIDTH-1:0] k);
      logic [LEN_WIDTH-1:0] c;
      c = '0;
      for (int i = 0; i < AXIS_IF_KEEP_WIDTH; i++) begin
         c = c + LEN_WIDTH'(k[i]);
      end
      return c;
   endfunction

   assign wr_free    = !wr_vld_q || m_wr_ready;
   assign slot_base  = BUF_BASE + ADDR_WIDTH'(wr_slot_q) * ADDR_WIDTH'(SLOT_SIZE);
   assign beat_addr  = slot_base + ADDR_WIDTH'(beat_idx_q) * ADDR_WIDTH'(AXIS_IF_KEEP_WIDTH);
   assign overflow   = (beat_idx_q >= BIDX_W'(BEATS));
   assign beat_bytes = popcnt(s_axis_tkeep);
   assign free_ok    = s_free_valid && (slots_used_q != '0);

   always_comb begin
      state_d       = state_q;
      wr_slot_d     = wr_slot_q;
      beat_idx_d    = beat_idx_q;
      len_d         = len_q;
      s_axis_tready = 1'b0;
      in_hs         = 1'b0;
      load          = 1'b0;
      desc_hs       = 1'b0;
      drop_done     = 1'b0;

      case (state_q)
         IDLE: begin
            s_axis_tready = run_q && (slots_used_q < SU_W'(SLOT_COUNT)) && wr_free;
            in_hs         = s_axis_tvalid && s_axis_tready;
            if (in_hs) begin
               load       = 1'b1;
               beat_idx_d = BIDX_W'(1);
               len_d      = beat_bytes;
               state_d    = s_axis_tlast ? WAIT_WR : WRITE;
            end
         end
         WRITE: begin
            s_axis_tready = wr_free;
            in_hs         = s_axis_tvalid && s_axis_tready;
            if (in_hs) begin
               if (overflow) begin
                  // Slot would overrun: abandon the frame, the slot stays ours for the next one.
                  if (s_axis_tlast) begin
                     drop_done  = 1'b1;
                     beat_idx_d = '0;
                     state_d    = IDLE;
                  end else begin
                     state_d = DROP;
                  end
               end else begin
                  load       = 1'b1;
                  beat_idx_d = beat_idx_q + BIDX_W'(1);
                  len_d      = len_q + beat_bytes;
                  if (s_axis_tlast) begin
                     state_d = WAIT_WR;
                  end
               end
            end
         end
         WAIT_WR: begin
            if (wr_vld_q && m_wr_ready) begin
               state_d = DESC;
            end
         end
         DESC: begin
            if (m_desc_ready) begin
               desc_hs    = 1'b1;
               wr_slot_d  = wr_slot_q + SLOT_W'(1);
               beat_idx_d = '0;
               state_d    = IDLE;
            end
         end
         DROP: begin
            s_axis_tready = 1'b1;
            in_hs         = s_axis_tvalid;
            if (in_hs && s_axis_tlast) begin
               drop_done  = 1'b1;
               beat_idx_d = '0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      run_d     = 1'b1;
      wr_vld_d  = wr_vld_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_strb_d = wr_strb_q;
      if (load) begin
         wr_vld_d  = 1'b1;
         wr_addr_d = beat_addr;
         wr_data_d = s_axis_tdata;
         wr_strb_d = s_axis_tkeep;
      end else if (m_wr_ready) begin
         wr_vld_d = 1'b0;
      end

      drop_count_d = drop_count_q;
      if (drop_done && (drop_count_q != '1)) begin
         drop_count_d = drop_count_q + 32'd1;
      end

      // A free landing on the same edge as a new descriptor cancels out.
      slots_used_d = slots_used_q;
      case ({desc_hs, free_ok})
         2'b10:   slots_used_d = slots_used_q + SU_W'(1);
         2'b01:   slots_used_d = slots_used_q - SU_W'(1);
         default: slots_used_d = slots_used_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         run_q        <= 1'b0;
         wr_slot_q    <= '0;
         beat_idx_q   <= '0;
         len_q        <= '0;
         slots_used_q <= '0;
         drop_count_q <= '0;
         wr_vld_q     <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         wr_strb_q    <= '0;
      end else begin
         state_q      <= state_d;
         run_q        <= run_d;
         wr_slot_q    <= wr_slot_d;
         beat_idx_q   <= beat_idx_d;
         len_q        <= len_d;
         slots_used_q <= slots_used_d;
         drop_count_q <= drop_count_d;
         wr_vld_q     <= wr_vld_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         wr_strb_q    <= wr_strb_d;
      end
   end

   assign m_wr_valid   = wr_vld_q;
   assign m_wr_addr    = wr_addr_q;
   assign m_wr_data    = wr_data_q;
   assign m_wr_strb    = wr_strb_q;
   assign m_desc_valid = (state_q == DESC);
   assign m_desc_addr  = slot_base;
   assign m_desc_len   = len_q;
   assign slots_used   = slots_used_q;
   assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_pspin_ingress_writer.sv
// Scoreboard bench for pspin_ingress_writer: stimulus pushes expected writes/descriptors, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_pspin_ingress_writer;

   localparam int DW = 512;
   localparam int KW = 64;
   localparam int AW = 32;
   localparam int LW = 16;
   localparam int SC = 8;
   localparam int SS = 2048;
   localparam int BEATS = SS / KW;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [KW-1:0] strb;
   } wr_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [LW-1:0] len;
   } desc_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          s_axis_tlast;
   logic [AW-1:0] m_wr_addr;
   logic [DW-1:0] m_wr_data;
   logic [KW-1:0] m_wr_strb;
   logic          m_wr_valid;
   logic          m_wr_ready;
   logic [AW-1:0] m_desc_addr;
   logic [LW-1:0] m_desc_len;
   logic          m_desc_valid;
   logic          m_desc_ready;
   logic          s_free_valid;
   logic [3:0]    slots_used;
   logic [31:0]   drop_count;

   pspin_ingress_writer #(
      .AXIS_IF_DATA_WIDTH (DW),
      .AXIS_IF_KEEP_WIDTH (KW),
      .ADDR_WIDTH         (AW),
      .BUF_BASE           (32'h0),
      .SLOT_SIZE          (SS),
      .SLOT_COUNT         (SC),
      .LEN_WIDTH          (LW)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_wr_addr     (m_wr_addr),
      .m_wr_data     (m_wr_data),
      .m_wr_strb     (m_wr_strb),
      .m_wr_valid    (m_wr_valid),
      .m_wr_ready    (m_wr_ready),
      .m_desc_addr   (m_desc_addr),
      .m_desc_len    (m_desc_len),
      .m_desc_valid  (m_desc_valid),
      .m_desc_ready  (m_desc_ready),
      .s_free_valid  (s_free_valid),
      .slots_used    (slots_used),
      .drop_count    (drop_count)
   );

   always #5 clk = ~clk;

   wr_t   exp_wr[$];
   desc_t exp_desc[$];
   int    checks = 0;
   int    errors = 0;
   int    model_slot = 0;
   int    model_used = 0;
   logic  stall_en = 1'b0;
   logic  holding = 1'b0;
   desc_t held;

   task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] mkdata(input int fid, input int b);
      logic [31:0] w;
      w = {fid[15:0], b[15:0]};
      return {16{w}};
   endfunction

   function automatic logic [KW-1:0] mkkeep(input int k);
      logic [KW-1:0] r;
      r = '0;
      for (int i = 0; i < k; i++) r[i] = 1'b1;
      return r;
   endfunction

   // Monitor: pops expected beats/descriptors on each handshake seen half a cycle before the edge.
   always @(negedge clk) begin
      wr_t   w;
      desc_t d;
      if (!rstn) begin
         holding = 1'b0;
      end else begin
         if (m_wr_valid && m_wr_ready) begin
            if (exp_wr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wr_unexpected: addr %0h, no write required", m_wr_addr);
            end else begin
               w = exp_wr.pop_front();
               chk("wr_addr", DW'(m_wr_addr), DW'(w.addr));
               chk("wr_data", m_wr_data, w.data);
               chk("wr_strb", DW'(m_wr_strb), DW'(w.strb));
            end
         end
         if (m_desc_valid) begin
            if (holding) begin
               chk("desc_stable_addr", DW'(m_desc_addr), DW'(held.addr));
               chk("desc_stable_len", DW'(m_desc_len), DW'(held.len));
            end
            if (m_desc_ready) begin
               holding = 1'b0;
               if (exp_desc.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL desc_unexpected: addr %0h len %0d, none required", m_desc_addr, m_desc_len);
               end else begin
                  d = exp_desc.pop_front();
                  chk("desc_addr", DW'(m_desc_addr), DW'(d.addr));
                  chk("desc_len", DW'(m_desc_len), DW'(d.len));
               end
            end else begin
               holding = 1'b1;
               held.addr = m_desc_addr;
               held.len  = m_desc_len;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (stall_en) begin
            m_wr_ready   = ($urandom_range(0, 3) != 0);
            m_desc_ready = ($urandom_range(0, 1) == 1);
         end else begin
            m_wr_ready   = 1'b1;
            m_desc_ready = 1'b1;
         end
      end
   end

   task automatic send_frame(input int nb, input int last_k, input int fid, input bit zmid, input int abort_after);
      int            len;
      int            bytes;
      int            cnt;
      bit            hs;
      logic [KW-1:0] kp;
      logic [AW-1:0] base;
      wr_t           w;
      desc_t         d;
      base = AW'(model_slot * SS);
      len  = 0;
      for (int b = 0; b < nb; b++) begin
         if (b == nb - 1) begin kp = mkkeep(last_k); bytes = last_k; end
         else if (zmid && b == 1) begin kp = '0; bytes = 0; end
         else begin kp = '1; bytes = KW; end
         len += bytes;
         if (b < BEATS) begin
            w.addr = base + AW'(b * KW);
            w.data = mkdata(fid, b);
            w.strb = kp;
            exp_wr.push_back(w);
         end
      end
      if (nb <= BEATS) begin
         d.addr = base;
         d.len  = LW'(len);
         exp_desc.push_back(d);
         model_slot = (model_slot + 1) % SC;
         model_used++;
      end
      for (int b = 0; b < nb; b++) begin
         if (b == nb - 1) kp = mkkeep(last_k);
         else if (zmid && b == 1) kp = '0;
         else kp = '1;
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = mkdata(fid, b);
         s_axis_tkeep  = kp;
         s_axis_tlast  = (b == nb - 1);
         cnt = 0;
         hs  = 1'b0;
         while (!hs && cnt < 2000) begin
            @(negedge clk);
            hs = s_axis_tready;
            @(posedge clk);
            #1;
            cnt++;
         end
         if (!hs) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout: frame %0d beat %0d tready stayed 0, required 1", fid, b);
            s_axis_tvalid = 1'b0;
            return;
         end
         if (b + 1 == abort_after) return;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_drain();
      int cnt;
      cnt = 0;
      while ((exp_wr.size() != 0 || exp_desc.size() != 0) && cnt < 5000) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      checks++;
      if (cnt >= 5000) begin
         errors++;
         $display("FAIL drain_timeout: pending writes %0d descs %0d, required 0", exp_wr.size(), exp_desc.size());
      end
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic free_pulse();
      s_free_valid = 1'b1;
      @(posedge clk);
      #1;
      s_free_valid = 1'b0;
      model_used--;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      s_axis_tvalid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      exp_wr.delete();
      exp_desc.delete();
      model_slot = 0;
      model_used = 0;
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_free_valid  = 1'b0;
      m_wr_ready    = 1'b1;
      m_desc_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wr_valid", DW'(m_wr_valid), DW'(0));
      chk("rst_desc_valid", DW'(m_desc_valid), DW'(0));
      chk("rst_slots_used", DW'(slots_used), DW'(0));
      chk("rst_drop_count", DW'(drop_count), DW'(0));
      chk("rst_tready", DW'(s_axis_tready), DW'(0));
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // 64-byte frame to slot 0, then 3-beat 132-byte frame to 0x800, then zero-keep middle beat (len 128) to 0x1000
      send_frame(1, 64, 1, 1'b0, 0);
      wait_drain();
      chk("used_after_f1", DW'(slots_used), DW'(1));
      send_frame(3, 4, 2, 1'b0, 0);
      wait_drain();
      chk("used_after_f2", DW'(slots_used), DW'(2));
      send_frame(3, 64, 3, 1'b1, 0);
      wait_drain();
      chk("used_after_f3", DW'(slots_used), DW'(3));

      // Fill all slots, then the next frame must be held off until a free pulse
      do_reset();
      for (int i = 0; i < SC; i++) send_frame(2, 64, 10 + i, 1'b0, 0);
      wait_drain();
      chk("used_full", DW'(slots_used), DW'(8));
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = mkdata(20, 0);
      s_axis_tkeep  = '1;
      s_axis_tlast  = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("full_tready", DW'(s_axis_tready), DW'(0));
         @(posedge clk);
         #1;
      end
      free_pulse();
      send_frame(1, 64, 20, 1'b0, 0);
      wait_drain();
      chk("used_refill", DW'(slots_used), DW'(8));

      // Oversize frame: 32 beats written at 0x800, beat 32 dropped, slot reused
      repeat (SC) free_pulse();
      chk("used_freed", DW'(slots_used), DW'(0));
      send_frame(BEATS + 1, 64, 30, 1'b0, 0);
      wait_drain();
      chk("drop_count", DW'(drop_count), DW'(1));
      chk("used_after_drop", DW'(slots_used), DW'(0));
      send_frame(2, 10, 31, 1'b0, 0);
      wait_drain();
      chk("used_after_reuse", DW'(slots_used), DW'(1));

      // Random write/descriptor stalls over 20 frames
      stall_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (model_used >= 7) begin
            wait_drain();
            repeat (4) free_pulse();
         end
         send_frame(1 + i % 5, 1 + (i * 13) % 64, 40 + i, (i % 4) == 2, 0);
      end
      wait_drain();
      stall_en = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("used_after_stalls", DW'(slots_used), DW'(model_used));
      chk("drop_after_stalls", DW'(drop_count), DW'(1));

      // Reset in the middle of a frame
      send_frame(4, 64, 70, 1'b0, 2);
      rstn = 1'b0;
      #1;
      chk("midrst_wr_valid", DW'(m_wr_valid), DW'(0));
      chk("midrst_desc_valid", DW'(m_desc_valid), DW'(0));
      chk("midrst_slots_used", DW'(slots_used), DW'(0));
      chk("midrst_drop_count", DW'(drop_count), DW'(0));
      chk("midrst_tready", DW'(s_axis_tready), DW'(0));
      chk("midrst_wr_addr", DW'(m_wr_addr), DW'(0));
      s_axis_tvalid = 1'b0;
      exp_wr.delete();
      exp_desc.delete();
      model_slot = 0;
      model_used = 0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      send_frame(2, 5, 71, 1'b0, 0);
      wait_drain();
      chk("used_post_reset", DW'(slots_used), DW'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
